// File: rtl/mem_channel_controller.sv
// mem_channel_controller
//   Arbitrates memory requests from NUM_CONSUMERS requesters onto NUM_CHANNELS
//   independent memory channels. Each channel grabs the lowest-indexed
//   unserved requester (read before write), forwards the request to memory,
//   relays the response back, and holds the consumer's ready until the
//   consumer drops its valid. All outputs are registered.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   consumer_read_valid/address    per-consumer read request
//   consumer_read_ready/data       per-consumer read completion and data
//   consumer_write_valid/address/data  per-consumer write request
//   consumer_write_ready           per-consumer write completion
//   mem_read_valid/address         per-channel read request to memory
//   mem_read_ready/data            per-channel memory read response
//   mem_write_valid/address/data   per-channel write request to memory
//   mem_write_ready                per-channel memory write response
module mem_channel_controller #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
   input  logic [ADDRESS_WIDTH-1:0] consumer_read_address [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
   output logic [DATA_WIDTH-1:0]    consumer_read_data [NUM_CONSUMERS],
   input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
   input  logic [ADDRESS_WIDTH-1:0] consumer_write_address [NUM_CONSUMERS],
   input  logic [DATA_WIDTH-1:0]    consumer_write_data [NUM_CONSUMERS],
   output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]  mem_read_valid,
   output logic [ADDRESS_WIDTH-1:0] mem_read_address [NUM_CHANNELS],
   input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
   input  logic [DATA_WIDTH-1:0]    mem_read_data [NUM_CHANNELS],
   output logic [NUM_CHANNELS-1:0]  mem_write_valid,
   output logic [ADDRESS_WIDTH-1:0] mem_write_address [NUM_CHANNELS],
   output logic [DATA_WIDTH-1:0]    mem_write_data [NUM_CHANNELS],
   input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } state_t;

   state_t                   state      [NUM_CHANNELS];
   state_t                   state_next [NUM_CHANNELS];
   logic [CW-1:0]            owner      [NUM_CHANNELS];
   logic [CW-1:0]            grant_idx  [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] serving;
   logic [NUM_CONSUMERS-1:0] claimed;
   logic [NUM_CONSUMERS-1:0] write_request;
   logic [NUM_CHANNELS-1:0]  grant, grant_read;
   logic [NUM_CHANNELS-1:0]  read_done, write_done, read_release, write_release;

   logic [NUM_CHANNELS-1:0]  write_valid_reg;
   logic [ADDRESS_WIDTH-1:0] write_address_reg [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]    write_data_reg    [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] write_ready_reg;

   // A read-only instance never sees write requests, so write states are unreachable.
   assign write_request = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

   // Next-state and per-channel events. 'claimed' accumulates across the channel
   // loop so a consumer taken by a lower channel is invisible to higher ones.
   always_comb begin
      claimed       = serving;
      grant         = '0;
      grant_read    = '0;
      read_done     = '0;
      write_done    = '0;
      read_release  = '0;
      write_release = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         grant_idx[i]  = '0;
         state_next[i] = state[i];
         case (state[i])
            IDLE: begin
               for (int j = 0; j < NUM_CONSUMERS; j++) begin
                  if (!grant[i] && !claimed[j] && (consumer_read_valid[j] || write_request[j])) begin
                     grant[i]      = 1'b1;
                     grant_read[i] = consumer_read_valid[j];
                     grant_idx[i]  = CW'(j);
                     claimed[j]    = 1'b1;
                  end
               end
               if (grant[i]) state_next[i] = grant_read[i] ? READ_WAITING : WRITE_WAITING;
            end
            READ_WAITING: begin
               if (mem_read_ready[i]) begin
                  read_done[i]  = 1'b1;
                  state_next[i] = READ_RELAYING;
               end
            end
            WRITE_WAITING: begin
               if (mem_write_ready[i]) begin
                  write_done[i] = 1'b1;
                  state_next[i] = WRITE_RELAYING;
               end
            end
            READ_RELAYING: begin
               if (!consumer_read_valid[owner[i]]) begin
                  read_release[i] = 1'b1;
                  state_next[i]   = IDLE;
               end
            end
            WRITE_RELAYING: begin
               if (!consumer_write_valid[owner[i]]) begin
                  write_release[i] = 1'b1;
                  state_next[i]    = IDLE;
               end
            end
            default: state_next[i] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (reset) state[i] <= IDLE;
         else       state[i] <= state_next[i];
      end
   end

   // Registered outputs, owner tracking and served flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         serving             <= '0;
         mem_read_valid      <= '0;
         write_valid_reg     <= '0;
         consumer_read_ready <= '0;
         write_ready_reg     <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            owner[i]             <= '0;
            mem_read_address[i]  <= '0;
            write_address_reg[i] <= '0;
            write_data_reg[i]    <= '0;
         end
         for (int c = 0; c < NUM_CONSUMERS; c++) consumer_read_data[c] <= '0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            // Address and data are captured only here; later consumer changes are ignored.
            if (grant[i]) begin
               owner[i]              <= grant_idx[i];
               serving[grant_idx[i]] <= 1'b1;
               if (grant_read[i]) begin
                  mem_read_valid[i]   <= 1'b1;
                  mem_read_address[i] <= consumer_read_address[grant_idx[i]];
               end else begin
                  write_valid_reg[i]   <= 1'b1;
                  write_address_reg[i] <= consumer_write_address[grant_idx[i]];
                  write_data_reg[i]    <= consumer_write_data[grant_idx[i]];
               end
            end
            if (read_done[i]) begin
               mem_read_valid[i]             <= 1'b0;
               consumer_read_data[owner[i]]  <= mem_read_data[i];
               consumer_read_ready[owner[i]] <= 1'b1;
            end
            if (write_done[i]) begin
               write_valid_reg[i]        <= 1'b0;
               write_ready_reg[owner[i]] <= 1'b1;
            end
            if (read_release[i]) begin
               consumer_read_ready[owner[i]] <= 1'b0;
               serving[owner[i]]             <= 1'b0;
            end
            if (write_release[i]) begin
               write_ready_reg[owner[i]] <= 1'b0;
               serving[owner[i]]         <= 1'b0;
            end
         end
      end
   end

   // Write outputs are tied off entirely in a read-only instance.
   assign mem_write_valid      = (WRITE_ENABLE != 0) ? write_valid_reg : '0;
   assign consumer_write_ready = (WRITE_ENABLE != 0) ? write_ready_reg : '0;
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_write_out
      assign mem_write_address[i] = (WRITE_ENABLE != 0) ? write_address_reg[i] : '0;
      assign mem_write_data[i]    = (WRITE_ENABLE != 0) ? write_data_reg[i] : '0;
   end

endmodule

// File: tb/tb_mem_channel_controller.sv
// tb_mem_channel_controller
//   Bench for mem_channel_controller. Instance 'a' is a 4-consumer, 2-channel
//   read/write controller; instance 'b' is a 4-consumer, 1-channel read-only one.
//   A shared behavioural memory answers requests three cycles after valid.
module tb_mem_channel_controller;
   localparam int DW  = 16;
   localparam int AW  = 8;
   localparam int NC  = 4;
   localparam int NCH = 2;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   logic [DW-1:0] mem [256];

   // Instance a signals
   logic [NC-1:0]  a_rd_valid, a_rd_ready, a_wr_valid, a_wr_ready;
   logic [AW-1:0]  a_rd_addr [NC];
   logic [AW-1:0]  a_wr_addr [NC];
   logic [DW-1:0]  a_rd_data [NC];
   logic [DW-1:0]  a_wr_data [NC];
   logic [NCH-1:0] a_mrv, a_mwv;
   logic [NCH-1:0] a_mrr = '0;
   logic [NCH-1:0] a_mwr = '0;
   logic [AW-1:0]  a_mra [NCH];
   logic [AW-1:0]  a_mwa [NCH];
   logic [DW-1:0]  a_mrd [NCH];
   logic [DW-1:0]  a_mwd [NCH];

   // Instance b signals
   logic [NC-1:0]  b_rd_valid, b_rd_ready, b_wr_valid, b_wr_ready;
   logic [AW-1:0]  b_rd_addr [NC];
   logic [AW-1:0]  b_wr_addr [NC];
   logic [DW-1:0]  b_rd_data [NC];
   logic [DW-1:0]  b_wr_data [NC];
   logic [0:0]     b_mrv, b_mwv;
   logic [0:0]     b_mrr = '0;
   logic [0:0]     b_mwr = '0;
   logic [AW-1:0]  b_mra [1];
   logic [AW-1:0]  b_mwa [1];
   logic [DW-1:0]  b_mrd [1];
   logic [DW-1:0]  b_mwd [1];

   mem_channel_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CONSUMERS(NC),
                            .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)) dut_a (
      .clk(clk), .reset(reset),
      .consumer_read_valid(a_rd_valid), .consumer_read_address(a_rd_addr),
      .consumer_read_ready(a_rd_ready), .consumer_read_data(a_rd_data),
      .consumer_write_valid(a_wr_valid), .consumer_write_address(a_wr_addr),
      .consumer_write_data(a_wr_data), .consumer_write_ready(a_wr_ready),
      .mem_read_valid(a_mrv), .mem_read_address(a_mra),
      .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
      .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
      .mem_write_data(a_mwd), .mem_write_ready(a_mwr));

   mem_channel_controller #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CONSUMERS(NC),
                            .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_b (
      .clk(clk), .reset(reset),
      .consumer_read_valid(b_rd_valid), .consumer_read_address(b_rd_addr),
      .consumer_read_ready(b_rd_ready), .consumer_read_data(b_rd_data),
      .consumer_write_valid(b_wr_valid), .consumer_write_address(b_wr_addr),
      .consumer_write_data(b_wr_data), .consumer_write_ready(b_wr_ready),
      .mem_read_valid(b_mrv), .mem_read_address(b_mra),
      .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
      .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
      .mem_write_data(b_mwd), .mem_write_ready(b_mwr));

   // Memory responders: ready pulses for one cycle LAT cycles after valid rises.
   int a_cnt [NCH] = '{0, 0};
   int b_cnt = 0;
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (a_mrr[c] || a_mwr[c]) begin
            a_mrr[c] = 1'b0;
            a_mwr[c] = 1'b0;
            a_cnt[c] = 0;
         end else if (a_mrv[c] || a_mwv[c]) begin
            a_cnt[c]++;
            if (a_cnt[c] >= LAT) begin
               if (a_mrv[c]) begin
                  a_mrr[c] = 1'b1;
                  a_mrd[c] = mem[a_mra[c]];
               end else begin
                  a_mwr[c] = 1'b1;
                  mem[a_mwa[c]] = a_mwd[c];
               end
            end
         end else begin
            a_cnt[c] = 0;
         end
      end
      if (b_mrr[0]) begin
         b_mrr[0] = 1'b0;
         b_cnt    = 0;
      end else if (b_mrv[0]) begin
         b_cnt++;
         if (b_cnt >= LAT) begin
            b_mrr[0] = 1'b1;
            b_mrd[0] = mem[b_mra[0]];
         end
      end else begin
         b_cnt = 0;
      end
   end

   // Read scoreboard for instance a: expectations pushed when a read is issued,
   // matched by consumer when that consumer's ready rises.
   typedef struct {
      int            cons;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb [$];
   int done_cnt [NC] = '{0, 0, 0, 0};
   logic [NC-1:0] a_rd_ready_prev = '0;

   always @(negedge clk) begin
      for (int c = 0; c < NC; c++) begin
         if (a_rd_ready[c] && !a_rd_ready_prev[c]) begin
            int idx;
            idx = -1;
            for (int k = 0; k < sb.size(); k++)
               if (idx < 0 && sb[k].cons == c) idx = k;
            checks++;
            if (idx < 0) begin
               fails++;
               $display("FAIL sb_unexpected: consumer %0d completed with %h, required no completion", c, a_rd_data[c]);
            end else begin
               if (a_rd_data[c] !== sb[idx].data) begin
                  fails++;
                  $display("FAIL sb_data consumer %0d: got %h, required %h", c, a_rd_data[c], sb[idx].data);
               end
               sb.delete(idx);
            end
            done_cnt[c]++;
         end
      end
      a_rd_ready_prev = a_rd_ready;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Full read on instance a with both channels idle. Called at a negedge.
   task automatic do_read(input int c, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      int n;
      a_rd_addr[c]  = a;
      a_rd_valid[c] = 1'b1;
      sb.push_back('{c, exp});
      @(negedge clk);
      check("rd_mem_valid", 32'(a_mrv), 32'(2'b01));
      check("rd_mem_addr", 32'(a_mra[0]), 32'(a));
      a_rd_addr[c] = ~a;
      n = 0;
      while (!a_rd_ready[c] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rd_ready_rise", 32'(a_rd_ready[c]), 1);
      a_rd_valid[c] = 1'b0;
      @(negedge clk);
      check("rd_ready_drop", 32'(a_rd_ready[c]), 0);
   endtask

   // Full write on instance a with both channels idle. Called at a negedge.
   task automatic do_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp);
      int n;
      a_wr_addr[c]  = a;
      a_wr_data[c]  = d;
      a_wr_valid[c] = 1'b1;
      @(negedge clk);
      check("wr_mem_valid", 32'(a_mwv), 32'(2'b01));
      check("wr_mem_addr", 32'(a_mwa[0]), 32'(a));
      check("wr_mem_data", 32'(a_mwd[0]), 32'(d));
      a_wr_addr[c] = ~a;
      a_wr_data[c] = ~d;
      n = 0;
      while (!a_wr_ready[c] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wr_ready_rise", 32'(a_wr_ready[c]), 1);
      check("wr_mem_content", 32'(mem[a]), 32'(exp));
      a_wr_valid[c] = 1'b0;
      @(negedge clk);
      check("wr_ready_drop", 32'(a_wr_ready[c]), 0);
   endtask

   typedef struct {
      int            cons;
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;
   vec_t vecs [7];

   initial begin
      int n;
      int viol;
      int fin_t [NC];
      int base [NC];

      vecs[0] = '{2, 1'b0, 8'h15, 16'h0000, 16'hBEEF};
      vecs[1] = '{0, 1'b0, 8'h03, 16'h0000, 16'hA503};
      vecs[2] = '{1, 1'b1, 8'h08, 16'h1234, 16'h1234};
      vecs[3] = '{3, 1'b0, 8'h08, 16'h0000, 16'h1234};
      vecs[4] = '{2, 1'b1, 8'hFF, 16'hFFFF, 16'hFFFF};
      vecs[5] = '{1, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
      vecs[6] = '{0, 1'b0, 8'h00, 16'h0000, 16'hA500};

      for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
      mem[8'h15] = 16'hBEEF;

      reset = 1'b1;
      a_rd_valid = '0; a_wr_valid = '0; b_rd_valid = '0; b_wr_valid = '0;
      for (int c = 0; c < NC; c++) begin
         a_rd_addr[c] = '0; a_wr_addr[c] = '0; a_wr_data[c] = '0;
         b_rd_addr[c] = '0; b_wr_addr[c] = '0; b_wr_data[c] = '0;
      end
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_a_mem_read_valid", 32'(a_mrv), 0);
      check("rst_a_mem_write_valid", 32'(a_mwv), 0);
      check("rst_a_read_ready", 32'(a_rd_ready), 0);
      check("rst_a_write_ready", 32'(a_wr_ready), 0);
      check("rst_a_read_addr", 32'(a_mra[0]), 0);
      check("rst_a_read_data", 32'(a_rd_data[2]), 0);
      check("rst_b_mem_read_valid", 32'(b_mrv), 0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven single transactions
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].is_wr) do_write(vecs[v].cons, vecs[v].addr, vecs[v].wdata, vecs[v].exp);
         else               do_read(vecs[v].cons, vecs[v].addr, vecs[v].exp);
         @(negedge clk);
      end

      // Contention: four simultaneous reads on two channels
      for (int c = 0; c < NC; c++) begin
         base[c]       = done_cnt[c];
         fin_t[c]      = -1;
         a_rd_addr[c]  = 8'h40 + 8'(c);
         a_rd_valid[c] = 1'b1;
         sb.push_back('{c, 16'hA540 + 16'(c)});
      end
      @(negedge clk);
      check("cont_grant_valid", 32'(a_mrv), 32'(2'b11));
      check("cont_ch0_addr", 32'(a_mra[0]), 32'h40);
      check("cont_ch1_addr", 32'(a_mra[1]), 32'h41);
      for (int cyc = 0; cyc < 200 && a_rd_valid != '0; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < NC; c++) begin
            if (a_rd_valid[c] && a_rd_ready[c]) begin
               a_rd_valid[c] = 1'b0;
               fin_t[c]      = cyc;
            end
         end
      end
      check("cont_all_done", 32'(a_rd_valid), 0);
      check("cont_order", 32'(fin_t[2] > fin_t[0] && fin_t[2] > fin_t[1] &&
                              fin_t[3] > fin_t[0] && fin_t[3] > fin_t[1]), 1);
      repeat (3) @(negedge clk);
      for (int c = 0; c < NC; c++) check("cont_once", 32'(done_cnt[c] - base[c]), 1);

      // Read has priority over write on the same consumer
      a_rd_addr[3]  = 8'h20;
      a_wr_addr[3]  = 8'h21;
      a_wr_data[3]  = 16'h5A5A;
      a_rd_valid[3] = 1'b1;
      a_wr_valid[3] = 1'b1;
      sb.push_back('{3, 16'hA520});
      @(negedge clk);
      check("rvw_read_first", 32'(a_mrv), 32'(2'b01));
      check("rvw_no_write", 32'(a_mwv), 0);
      check("rvw_read_addr", 32'(a_mra[0]), 32'h20);
      n = 0;
      while (!a_rd_ready[3] && n < 100) begin @(negedge clk); n++; end
      check("rvw_read_done", 32'(a_rd_ready[3]), 1);
      a_rd_valid[3] = 1'b0;
      n = 0;
      while (!a_wr_ready[3] && n < 100) begin @(negedge clk); n++; end
      check("rvw_write_done", 32'(a_wr_ready[3]), 1);
      check("rvw_write_content", 32'(mem[8'h21]), 32'h5A5A);
      a_wr_valid[3] = 1'b0;
      @(negedge clk);
      check("rvw_write_ready_drop", 32'(a_wr_ready[3]), 0);
      @(negedge clk);

      // Reset while a read is waiting on memory
      a_rd_addr[0]  = 8'h50;
      a_rd_valid[0] = 1'b1;
      @(negedge clk);
      check("rstmid_waiting", 32'(a_mrv), 32'(2'b01));
      @(negedge clk);
      reset         = 1'b1;
      a_rd_valid[0] = 1'b0;
      @(negedge clk);
      check("rstmid_mem_valid", 32'(a_mrv), 0);
      check("rstmid_mem_addr", 32'(a_mra[0]), 0);
      check("rstmid_read_ready", 32'(a_rd_ready), 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rstmid_no_late_ready", 32'(a_rd_ready), 0);
      do_read(0, 8'h51, 16'hA551);
      @(negedge clk);

      // Read-only instance: write requests ignored, reads still complete
      b_wr_valid    = '1;
      b_rd_addr[1]  = 8'h60;
      b_rd_valid[1] = 1'b1;
      viol = 0;
      n    = 0;
      while (!b_rd_ready[1] && n < 100) begin
         @(negedge clk);
         if (b_mwv != '0 || b_wr_ready != '0) viol++;
         n++;
      end
      check("we0_read_done", 32'(b_rd_ready[1]), 1);
      check("we0_read_data", 32'(b_rd_data[1]), 32'hA560);
      check("we0_no_write", 32'(viol), 0);
      check("we0_write_addr", 32'(b_mwa[0]), 0);
      check("we0_write_data", 32'(b_mwd[0]), 0);
      b_rd_valid[1] = 1'b0;
      @(negedge clk);
      check("we0_read_ready_drop", 32'(b_rd_ready[1]), 0);
      b_wr_valid = '0;
      @(negedge clk);

      check("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
